// File: rtl/regfile_sb.sv
// Multi-read-port register file for the decode stage: dual write ports with
// write-through bypass, optional hardwired zero register and a busy scoreboard.
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr0_en,
  input  logic [ADDR_W-1:0]        wr0_addr,
  input  logic [DATA_W-1:0]        wr0_data,
  input  logic                     wr1_en,
  input  logic [ADDR_W-1:0]        wr1_addr,
  input  logic [DATA_W-1:0]        wr1_data,
  input  logic                     claim_en,
  input  logic [ADDR_W-1:0]        claim_addr,
  output logic [ADDR_W:0]          busy_count
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CW    = ADDR_W + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  r_busy;
  logic [CW-1:0]     r_busy_count;

  logic              w_wr0_ok;
  logic              w_wr1_ok;
  logic              w_claim_ok;
  logic [DEPTH-1:0]  w_busy_nxt;
  logic              w_inc;
  logic              w_dec0;
  logic              w_dec1;

  // Writes and claims aimed at a hardwired zero register are dropped here.
  assign w_wr0_ok   = wr0_en   && !((ZERO_REG != 0) && (wr0_addr   == '0));
  assign w_wr1_ok   = wr1_en   && !((ZERO_REG != 0) && (wr1_addr   == '0));
  assign w_claim_ok = claim_en && !((ZERO_REG != 0) && (claim_addr == '0));

  always_comb begin
    w_busy_nxt = r_busy;
    if (w_wr0_ok) w_busy_nxt[wr0_addr] = 1'b0;
    if (w_wr1_ok) w_busy_nxt[wr1_addr] = 1'b0;
    // The claiming producer owns the register even if an older one retires now.
    if (w_claim_ok) w_busy_nxt[claim_addr] = 1'b1;
  end

  // A write only decrements when its register is busy and not being re-claimed;
  // wr1 to the same register as wr0 must not count a second time.
  assign w_inc  = w_claim_ok && !r_busy[claim_addr];
  assign w_dec0 = w_wr0_ok && r_busy[wr0_addr] &&
                  !(w_claim_ok && (claim_addr == wr0_addr));
  assign w_dec1 = w_wr1_ok && r_busy[wr1_addr] &&
                  !(w_claim_ok && (claim_addr == wr1_addr)) &&
                  !(w_wr0_ok && (wr0_addr == wr1_addr));

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < DEPTH; k++) r_mem[k] <= '0;
    end else begin
      if (w_wr0_ok) r_mem[wr0_addr] <= wr0_data;
      if (w_wr1_ok) r_mem[wr1_addr] <= wr1_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_busy       <= '0;
      r_busy_count <= '0;
    end else begin
      r_busy       <= w_busy_nxt;
      r_busy_count <= r_busy_count + CW'(w_inc) - CW'(w_dec0) - CW'(w_dec1);
    end
  end

  assign busy_count = r_busy_count;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] w_ra;
    logic              w_zero;
    logic              w_hit0;
    logic              w_hit1;

    assign w_ra   = rd_addr[i*ADDR_W +: ADDR_W];
    assign w_zero = (ZERO_REG != 0) && (w_ra == '0);
    assign w_hit1 = wr1_en && (wr1_addr == w_ra);
    assign w_hit0 = wr0_en && (wr0_addr == w_ra);

    assign rd_data[i*DATA_W +: DATA_W] = (!reset || w_zero) ? '0 :
                                         w_hit1 ? wr1_data :
                                         w_hit0 ? wr0_data :
                                         r_mem[w_ra];
    // Bypassed data is arriving this cycle, so the consumer need not stall.
    assign rd_busy[i] = reset && !w_zero && !w_hit1 && !w_hit0 && r_busy[w_ra];
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Randomized self-checking bench for regfile_sb against an array-based
// reference model, preceded by directed scoreboard and bypass scenarios.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        wr0_en, wr1_en, claim_en;
  logic [4:0]  wr0_addr, wr1_addr, claim_addr;
  logic [31:0] wr0_data, wr1_data;
  logic [5:0]  busy_count;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] m_mem  [32];
  bit          m_busy [32];

  regfile_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1)) dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_busy(rd_busy), .wr0_en(wr0_en), .wr0_addr(wr0_addr),
    .wr0_data(wr0_data), .wr1_en(wr1_en), .wr1_addr(wr1_addr),
    .wr1_data(wr1_data), .claim_en(claim_en), .claim_addr(claim_addr),
    .busy_count(busy_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_data(input logic [4:0] a);
    if (!reset || a == 5'd0) return 32'd0;
    if (wr1_en && wr1_addr == a) return wr1_data;
    if (wr0_en && wr0_addr == a) return wr0_data;
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    if (!reset || a == 5'd0) return 1'b0;
    if ((wr1_en && wr1_addr == a) || (wr0_en && wr0_addr == a)) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic int popcount();
    int n = 0;
    for (int k = 0; k < 32; k++) n += int'(m_busy[k]);
    return n;
  endfunction

  task automatic idle();
    reset = 1'b1; rd_addr = '0;
    wr0_en = 0; wr0_addr = 0; wr0_data = 0;
    wr1_en = 0; wr1_addr = 0; wr1_data = 0;
    claim_en = 0; claim_addr = 0;
  endtask

  // Checks all outputs mid-cycle, then advances the model across the edge.
  task automatic cycle();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rd_data%0d", i), 64'(rd_data[i*32 +: 32]), 64'(exp_data(rd_addr[i*5 +: 5])));
      chk($sformatf("rd_busy%0d", i), 64'(rd_busy[i]), 64'(exp_busy(rd_addr[i*5 +: 5])));
    end
    chk("busy_count", 64'(busy_count), 64'(popcount()));
    @(posedge clk);
    if (!reset) begin
      for (int k = 0; k < 32; k++) begin m_mem[k] = 0; m_busy[k] = 0; end
    end else begin
      if (wr0_en && wr0_addr != 0) begin m_mem[wr0_addr] = wr0_data; m_busy[wr0_addr] = 0; end
      if (wr1_en && wr1_addr != 0) begin m_mem[wr1_addr] = wr1_data; m_busy[wr1_addr] = 0; end
      if (claim_en && claim_addr != 0) m_busy[claim_addr] = 1;
    end
    #1;
  endtask

  initial begin
    for (int k = 0; k < 32; k++) begin m_mem[k] = 0; m_busy[k] = 0; end
    idle(); reset = 1'b0;
    cycle(); cycle();

    // Reset clears a previously written register.
    idle(); wr0_en = 1; wr0_addr = 5; wr0_data = 32'hDEADBEEF; cycle();
    idle(); rd_addr[4:0] = 5; #1;
    chk("pre_rst_r5", 64'(rd_data[31:0]), 64'h DEADBEEF);
    reset = 1'b0; #1;
    chk("in_rst_r5", 64'(rd_data[31:0]), 64'h0);
    cycle();
    idle(); rd_addr[4:0] = 5; #1;
    chk("post_rst_r5", 64'(rd_data[31:0]), 64'h0);
    chk("post_rst_cnt", 64'(busy_count), 64'h0);
    cycle();

    // Same-cycle dual write: wr1 wins through bypass and array.
    idle(); rd_addr[4:0] = 3;
    wr0_en = 1; wr0_addr = 3; wr0_data = 32'h11;
    wr1_en = 1; wr1_addr = 3; wr1_data = 32'h22; #1;
    chk("bypass_r3", 64'(rd_data[31:0]), 64'h22);
    cycle();
    idle(); rd_addr[4:0] = 3; #1;
    chk("array_r3", 64'(rd_data[31:0]), 64'h22);
    cycle();

    // Zero register ignores writes and claims.
    idle(); wr0_en = 1; wr0_addr = 0; wr0_data = 32'hFFFFFFFF;
    claim_en = 1; claim_addr = 0; cycle();
    idle(); #1;
    chk("zero_data", 64'(rd_data[31:0]), 64'h0);
    chk("zero_busy", 64'(rd_busy[0]), 64'h0);
    chk("zero_cnt", 64'(busy_count), 64'h0);
    cycle();

    // Claim then retire r7.
    idle(); claim_en = 1; claim_addr = 7; cycle();
    idle(); rd_addr[4:0] = 7; #1;
    chk("claim_busy", 64'(rd_busy[0]), 64'h1);
    chk("claim_cnt", 64'(busy_count), 64'h1);
    wr1_en = 1; wr1_addr = 7; wr1_data = 32'h55; #1;
    chk("retire_busy", 64'(rd_busy[0]), 64'h0);
    chk("retire_data", 64'(rd_data[31:0]), 64'h55);
    cycle();
    idle(); #1;
    chk("retire_cnt", 64'(busy_count), 64'h0);

    // Claim and write to the same busy register in one cycle.
    claim_en = 1; claim_addr = 9; cycle();
    idle(); claim_en = 1; claim_addr = 9; wr0_en = 1; wr0_addr = 9; wr0_data = 32'h7; cycle();
    idle(); rd_addr[4:0] = 9; #1;
    chk("coll_data", 64'(rd_data[31:0]), 64'h7);
    chk("coll_busy", 64'(rd_busy[0]), 64'h1);
    chk("coll_cnt", 64'(busy_count), 64'h1);
    wr1_en = 1; wr1_addr = 9; wr1_data = 32'h8; cycle();

    // Two registers retired at once, then both ports on one register.
    idle(); claim_en = 1; claim_addr = 1; cycle();
    idle(); claim_en = 1; claim_addr = 2; cycle();
    idle(); #1; chk("multi_cnt2", 64'(busy_count), 64'h2);
    wr0_en = 1; wr0_addr = 1; wr1_en = 1; wr1_addr = 2; cycle();
    idle(); #1; chk("multi_cnt0", 64'(busy_count), 64'h0);
    claim_en = 1; claim_addr = 1; cycle();
    idle(); claim_en = 1; claim_addr = 2; cycle();
    idle(); wr0_en = 1; wr0_addr = 1; wr1_en = 1; wr1_addr = 1; cycle();
    idle(); rd_addr = {5'd2, 5'd1}; #1;
    chk("same_cnt1", 64'(busy_count), 64'h1);
    chk("same_r1", 64'(rd_busy[0]), 64'h0);
    chk("same_r2", 64'(rd_busy[1]), 64'h1);
    cycle();

    // Random traffic, addresses biased to a small window to provoke collisions.
    for (int n = 0; n < 600; n++) begin
      reset      = ($urandom_range(0, 59) != 0);
      rd_addr    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      wr0_en     = $urandom_range(0, 2) == 0;
      wr0_addr   = 5'($urandom_range(0, 7));
      wr0_data   = $urandom;
      wr1_en     = $urandom_range(0, 2) == 0;
      wr1_addr   = 5'($urandom_range(0, 7));
      wr1_data   = $urandom;
      claim_en   = $urandom_range(0, 1) == 0;
      claim_addr = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) rd_addr = {5'($urandom), 5'($urandom)};
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
